// File: rtl/otter_lsu.sv
// RV32I load/store unit: one outstanding bus access at a time, with byte-lane steering,
// load sign/zero extension, alignment/funct3 checking and a bus ack timeout.
module otter_lsu #(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [3:0]  mem_be,
  output logic [31:0] mem_wdata,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic [1:0]  rsp_err
);
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [1:0] {IDLE, BUS, RESP} state_t;

  state_t          r_state;
  logic [CW-1:0]   r_cnt;
  logic            r_we;
  logic [2:0]      r_f3;
  logic [1:0]      r_off;

  logic            w_illegal;
  logic            w_misal;
  logic [3:0]      w_be;
  logic [31:0]     w_wdata;
  logic [31:0]     w_lane;
  logic [15:0]     w_half;
  logic [31:0]     w_ld;

  assign req_ready = (r_state == IDLE);

  always_comb begin
    if (req_we) w_illegal = req_funct3[2] | (req_funct3 == 3'b011);
    else        w_illegal = (req_funct3 == 3'b011) | (req_funct3 == 3'b110) | (req_funct3 == 3'b111);
  end

  assign w_misal = ((req_funct3[1:0] == 2'b01) & req_addr[0]) |
                   ((req_funct3[1:0] == 2'b10) & (req_addr[1:0] != 2'b00));

  always_comb begin
    w_be    = 4'hF;
    w_wdata = req_wdata;
    case (req_funct3[1:0])
      2'b00: begin
        w_be    = 4'b0001 << req_addr[1:0];
        w_wdata = {4{req_wdata[7:0]}};
      end
      2'b01: begin
        w_be    = req_addr[1] ? 4'b1100 : 4'b0011;
        w_wdata = {2{req_wdata[15:0]}};
      end
      default: begin
        w_be    = 4'hF;
        w_wdata = req_wdata;
      end
    endcase
  end

  // Load data is steered from the lane captured at accept time.
  always_comb begin
    w_lane = mem_rdata >> {r_off, 3'b000};
    w_half = r_off[1] ? mem_rdata[31:16] : mem_rdata[15:0];
    case (r_f3)
      3'b000:  w_ld = {{24{w_lane[7]}}, w_lane[7:0]};
      3'b001:  w_ld = {{16{w_half[15]}}, w_half};
      3'b100:  w_ld = {24'd0, w_lane[7:0]};
      3'b101:  w_ld = {16'd0, w_half};
      default: w_ld = mem_rdata;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= IDLE;
      r_cnt     <= '0;
      r_we      <= 1'b0;
      r_f3      <= 3'd0;
      r_off     <= 2'd0;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= 32'd0;
      mem_be    <= 4'd0;
      mem_wdata <= 32'd0;
      rsp_valid <= 1'b0;
      rsp_rdata <= 32'd0;
      rsp_err   <= 2'b00;
    end else begin
      rsp_valid <= 1'b0;
      case (r_state)
        IDLE: if (req_valid) begin
          if (w_illegal || w_misal) begin
            r_state   <= RESP;
            rsp_valid <= 1'b1;
            rsp_rdata <= 32'd0;
            rsp_err   <= w_illegal ? 2'b11 : 2'b01;
          end else begin
            r_state   <= BUS;
            r_cnt     <= '0;
            r_we      <= req_we;
            r_f3      <= req_funct3;
            r_off     <= req_addr[1:0];
            mem_req   <= 1'b1;
            mem_we    <= req_we;
            mem_addr  <= {req_addr[31:2], 2'b00};
            mem_be    <= w_be;
            mem_wdata <= w_wdata;
          end
        end
        BUS: begin
          // An ack on the final allowed cycle still completes normally.
          if (mem_ack) begin
            r_state   <= RESP;
            mem_req   <= 1'b0;
            rsp_valid <= 1'b1;
            rsp_rdata <= r_we ? 32'd0 : w_ld;
            rsp_err   <= 2'b00;
          end else if (r_cnt == CW'(TIMEOUT_CYCLES - 1)) begin
            r_state   <= RESP;
            mem_req   <= 1'b0;
            rsp_valid <= 1'b1;
            rsp_rdata <= 32'd0;
            rsp_err   <= 2'b10;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        RESP:    r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end
endmodule

// File: doc/otter_lsu.md
OTTER_LSU -- requirements
Module: otter_lsu

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 255: max cycles mem_req may wait for mem_ack before the request is aborted.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  synchronous, active-high reset.
REQ-004 req_valid  input  1  execute stage presents a load/store.
REQ-005 req_ready  output  1  LSU can accept a request this cycle.
REQ-006 req_we  input  1  1=store, 0=load.
REQ-007 req_funct3  input  3  RV32I size/sign code.
REQ-008 req_addr  input  32  byte address, taken from the ALU result (ALU_ADD of rs1+imm).
REQ-009 req_wdata  input  32  store data (rs2).
REQ-010 mem_req  output  1  bus request, held until ack or abort.
REQ-011 mem_we  output  1  bus write enable.
REQ-012 mem_addr  output  32  word-aligned address: req_addr with bits [1:0] cleared.
REQ-013 mem_be  output  4  byte enables.
REQ-014 mem_wdata  output  32  lane-replicated store data.
REQ-015 mem_ack  input  1  bus completion, one-cycle pulse.
REQ-016 mem_rdata  input  32  read word, valid when mem_ack=1.
REQ-017 rsp_valid  output  1  one-cycle completion pulse toward writeback.
REQ-018 rsp_rdata  output  32  extended load result; 0 for stores and errors.
REQ-019 rsp_err  output  2  00 ok, 01 misaligned, 10 bus timeout, 11 illegal funct3.

Function
REQ-020 FSM states: IDLE, BUS, RESP; req_ready=1 only in IDLE.
REQ-021 Handshake: request accepted on the cycle when req_valid and req_ready are both 1; all req_* fields are latched on that edge.
REQ-022 Legal funct3 values for loads: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU. Legal funct3 values for stores: 000 SB, 001 SH, 010 SW. Any other value is illegal.
REQ-023 Misaligned accesses: halfword with addr[0]=1; word with addr[1:0]!=00.
REQ-024 Accept of an illegal or misaligned request: IDLE->RESP directly; no mem_req; rsp_err set accordingly; illegal funct3 takes priority over misaligned.
REQ-025 Accept of a legal request: IDLE->BUS; mem_req=1 from the next cycle; mem_* fields stay stable until leaving BUS.
REQ-026 Byte enables: byte access gives mem_be=0001<<addr[1:0]; halfword gives 0011 (addr[1]=0) or 1100 (addr[1]=1); word gives 1111. mem_be is also driven for loads.
REQ-027 Store data: SB replicates wdata[7:0] into all 4 lanes; SH replicates wdata[15:0] into both halves; SW passes wdata unchanged.
REQ-028 Load data: select the lane addressed by addr[1:0]. LB/LH sign-extend; LBU/LHU zero-extend; LW passes the word unchanged.
REQ-029 In BUS, mem_ack=1 latches the result and moves to RESP. Latency from accept to rsp_valid is (ack wait + 2) cycles; with ack on the first mem_req cycle, rsp_valid occurs 2 cycles after accept.
REQ-030 Timeout counter clears on entry to BUS and increments each BUS cycle without ack. When it reaches TIMEOUT_CYCLES: mem_req drops, go to RESP, rsp_err=10, rsp_rdata=0.
REQ-031 If mem_ack coincides with the timeout cycle, the ack wins and rsp_err=00.
REQ-032 RESP lasts exactly one cycle: rsp_valid=1, then return to IDLE. A back-to-back request is accepted no earlier than the cycle after RESP.
REQ-033 mem_ack received outside BUS is ignored.
REQ-034 rsp_rdata and rsp_err hold their value until the next RESP.

Reset
REQ-035 When rst=1 at a clock edge: state=IDLE, timeout counter=0, mem_req=0, mem_we=0, mem_addr=0, mem_be=0, mem_wdata=0, rsp_valid=0, rsp_rdata=0, rsp_err=00. req_ready=1 on the cycle after rst is released.
REQ-036 Reset asserted in BUS or RESP aborts the access: no rsp_valid is ever produced for it, and any later mem_ack for it is ignored.

Verification
REQ-037 LB at addr 0x1003, mem_rdata=0x80FF_1234, ack on the first cycle -> mem_addr=0x1000, mem_be=1000, rsp_rdata=0xFFFF_FF80, rsp_err=00, rsp_valid 2 cycles after accept.
REQ-038 SH at addr 0x2002, wdata=0xAAAA_BEEF -> mem_we=1, mem_be=1100, mem_wdata=0xBEEF_BEEF; after ack, rsp_rdata=0, rsp_err=00.
REQ-039 LW at addr 0x3001 -> mem_req never asserted; rsp_valid on the cycle after accept with rsp_err=01.
REQ-040 LHU at 0x0, no ack, TIMEOUT_CYCLES=4 -> mem_req high for exactly 4 cycles, then rsp_err=10 and rsp_rdata=0.
REQ-041 funct3=011 load -> rsp_err=11 with no bus activity; a funct3=011 request at addr 0x1 also reports 11.
REQ-042 rst pulsed during BUS, then a late mem_ack -> mem_req=0 after the reset edge, no rsp_valid, req_ready=1.
